// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register offsets, TCON bit indices and interrupt FSM encoding
package timer_pkg;

    localparam logic [31:0] TH_OFS   = 32'd0;
    localparam logic [31:0] TL_OFS   = 32'd4;
    localparam logic [31:0] TCON_OFS = 32'd8;
    localparam logic [31:0] OVR_OFS  = 32'd12;

    localparam int EN_BIT     = 0;
    localparam int IE_BIT     = 1;
    localparam int STATUS_BIT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// rtl/timer_ctrl_if.sv - CPU register bus between the processor and timer_ctrl
interface timer_ctrl_if;
    logic [31:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output wr_en, output rd_en, output wdata, input rdata);
    modport slave  (input addr, input wr_en, input rd_en, input wdata, output rdata);
endinterface

// File: rtl/timer_irq_fsm.sv
// rtl/timer_irq_fsm.sv - expiry edge detect, interrupt FSM, replay flag and saturating overrun count
module timer_irq_fsm
    import timer_pkg::*;
#(
    parameter int OVR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             timer_state,
    input  logic             ie,
    input  logic             status_clr,
    input  logic             ovr_clr,
    input  logic             irq_ack,
    input  logic             eret,
    output logic             rise,
    output logic             irq,
    output logic [OVR_W-1:0] ovr
);

    irq_state_t       state, state_n;
    logic             state_d;
    logic             replay, replay_n;
    logic             ovr_inc;
    logic [OVR_W-1:0] ovr_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            state_d <= 1'b1;
            replay  <= 1'b0;
            ovr     <= '0;
        end else begin
            state   <= state_n;
            state_d <= timer_state;
            replay  <= replay_n;
            ovr     <= ovr_n;
        end
    end

    // state_d resets high so the counter's idle-high level never looks like an expiry
    assign rise = timer_state & ~state_d & ie;
    assign irq  = (state == PENDING);

    always_comb begin
        state_n  = state;
        replay_n = replay;
        ovr_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_n = PENDING;
            end
            PENDING: begin
                if (irq_ack)                 state_n = SERVICE;
                else if (status_clr && !rise) state_n = IDLE;
            end
            SERVICE: begin
                if (rise) begin
                    ovr_inc  = 1'b1;
                    replay_n = 1'b1;
                end
                if (eret) begin
                    state_n  = (replay || rise) ? PENDING : IDLE;
                    replay_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ovr_n = ovr;
        if (ovr_clr)
            ovr_n = ovr_inc ? {{(OVR_W-1){1'b0}}, 1'b1} : '0;
        else if (ovr_inc && (ovr != {OVR_W{1'b1}}))
            ovr_n = ovr + 1'b1;
    end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - memory-mapped timer control registers, TL readback and interrupt request
module timer_ctrl
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h4000_0000,
    parameter int          AUTO_RELOAD = 1,
    parameter int          OVR_W       = 8
) (
    input  logic          clk,
    input  logic          reset,
    timer_ctrl_if.slave   bus,
    output logic [31:0]   TH,
    output logic [1:0]    timer_CON,
    input  logic [31:0]   TL,
    input  logic          timer_State,
    output logic          irq,
    input  logic          irq_ack,
    input  logic          eret
);

    logic [31:0]      th_q;
    logic             en, ie, status, reload_pulse;
    logic [31:0]      ofs;
    logic             sel_th, sel_tl, sel_tcon, sel_ovr;
    logic             status_clr, ovr_clr, rise;
    logic [OVR_W-1:0] ovr;

    assign ofs      = bus.addr - BASE;
    assign sel_th   = (ofs == TH_OFS);
    assign sel_tl   = (ofs == TL_OFS);
    assign sel_tcon = (ofs == TCON_OFS);
    assign sel_ovr  = (ofs == OVR_OFS);

    assign status_clr = bus.wr_en && sel_tcon && bus.wdata[STATUS_BIT];
    assign ovr_clr    = bus.wr_en && sel_ovr;

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q         <= '0;
            en           <= 1'b0;
            ie           <= 1'b0;
            status       <= 1'b0;
            reload_pulse <= 1'b0;
        end else begin
            if (bus.wr_en && sel_th) th_q <= bus.wdata;
            if (bus.wr_en && sel_tcon) begin
                en <= bus.wdata[EN_BIT];
                ie <= bus.wdata[IE_BIT];
            end
            // a fresh expiry beats a simultaneous software clear
            if (rise)            status <= 1'b1;
            else if (status_clr) status <= 1'b0;
            reload_pulse <= rise && en && (AUTO_RELOAD != 0);
        end
    end

    timer_irq_fsm #(.OVR_W(OVR_W)) u_irq_fsm (
        .clk         (clk),
        .reset       (reset),
        .timer_state (timer_State),
        .ie          (ie),
        .status_clr  (status_clr),
        .ovr_clr     (ovr_clr),
        .irq_ack     (irq_ack),
        .eret        (eret),
        .rise        (rise),
        .irq         (irq),
        .ovr         (ovr)
    );

    assign TH        = th_q;
    assign timer_CON = {ie, en & ~reload_pulse};

    always_comb begin
        bus.rdata = '0;
        if (bus.rd_en) begin
            if (sel_th)        bus.rdata = th_q;
            else if (sel_tl)   bus.rdata = TL;
            else if (sel_tcon) bus.rdata = {29'd0, status, ie, en};
            else if (sel_ovr)  bus.rdata = 32'(ovr);
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - self-checking bench for timer_ctrl: vector table, directed sequences, random vs model
module tb_timer_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] th_out;
    logic [1:0]  tcon_out;
    logic [31:0] tl;
    logic        ts;
    logic        irq;
    logic        ack;
    logic        eret;

    int n_tests = 0;
    int n_fail  = 0;

    timer_ctrl_if bus ();

    timer_ctrl #(.BASE(BASE), .AUTO_RELOAD(1), .OVR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .TH          (th_out),
        .timer_CON   (tcon_out),
        .TL          (tl),
        .timer_State (ts),
        .irq         (irq),
        .irq_ack     (ack),
        .eret        (eret)
    );

    always #5 clk = ~clk;

    // Reference model: plain software view of the registers and the interrupt lifecycle
    logic [31:0] m_th;
    logic        m_en, m_ie, m_st, m_reload, m_prev;
    logic [7:0]  m_ovr;
    bit          m_pend, m_serv, m_replay;

    function automatic logic [31:0] model_rd(logic [31:0] a, logic rd, logic [31:0] tlv);
        if (!rd) return 32'd0;
        case (a - BASE)
            32'd0:   return m_th;
            32'd4:   return tlv;
            32'd8:   return {29'd0, m_st, m_ie, m_en};
            32'd12:  return {24'd0, m_ovr};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        bit expiry, wr_tcon, wr_ovr, sw_clr, bump;
        if (reset) begin
            m_th = 0; m_en = 0; m_ie = 0; m_st = 0; m_reload = 0; m_prev = 1;
            m_ovr = 0; m_pend = 0; m_serv = 0; m_replay = 0;
            return;
        end
        expiry  = ts && !m_prev && m_ie;
        wr_tcon = bus.wr_en && (bus.addr == BASE + 32'd8);
        wr_ovr  = bus.wr_en && (bus.addr == BASE + 32'd12);
        sw_clr  = wr_tcon && bus.wdata[2];
        bump    = 0;
        if (m_pend) begin
            if (ack) begin m_pend = 0; m_serv = 1; end
            else if (sw_clr && !expiry) m_pend = 0;
        end else if (m_serv) begin
            if (expiry) begin bump = 1; m_replay = 1; end
            if (eret) begin m_serv = 0; m_pend = m_replay; m_replay = 0; end
        end else if (expiry) begin
            m_pend = 1;
        end
        if (wr_ovr) m_ovr = bump ? 8'd1 : 8'd0;
        else if (bump && m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
        m_reload = expiry && m_en;
        if (expiry) m_st = 1;
        else if (sw_clr) m_st = 0;
        if (bus.wr_en && bus.addr == BASE) m_th = bus.wdata;
        if (wr_tcon) begin m_en = bus.wdata[0]; m_ie = bus.wdata[1]; end
        m_prev = ts;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd_chk(string name, logic [31:0] ofs, logic [31:0] exp);
        bus.addr  = BASE + ofs;
        bus.rd_en = 1'b1;
        #1;
        check(name, bus.rdata, exp);
        bus.rd_en = 1'b0;
    endtask

    task automatic wr(logic [31:0] ofs, logic [31:0] d);
        bus.addr  = BASE + ofs;
        bus.wdata = d;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_ack();  ack = 1;  tick(); ack = 0;  endtask
    task automatic pulse_eret(); eret = 1; tick(); eret = 0; endtask
    task automatic expire();     ts = 0; tick(); ts = 1; tick(); endtask

    typedef struct {
        logic [31:0] ofs;
        logic [31:0] tlv;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[6];

    initial begin
        reset = 1; ts = 1; ack = 0; eret = 0; tl = 32'h1234;
        bus.addr = BASE; bus.wr_en = 0; bus.rd_en = 0; bus.wdata = 0;
        tick(); tick();
        reset = 0;

        vecs[0] = '{32'd0,  32'h1234,     32'd0};
        vecs[1] = '{32'd4,  32'h1234,     32'h1234};
        vecs[2] = '{32'd8,  32'h1234,     32'd0};
        vecs[3] = '{32'd12, 32'h1234,     32'd0};
        vecs[4] = '{32'd16, 32'h1234,     32'd0};
        vecs[5] = '{32'd4,  32'hDEADBEEF, 32'hDEADBEEF};
        for (int i = 0; i < 6; i++) begin
            tl = vecs[i].tlv;
            rd_chk($sformatf("reset_rd[%0d]", i), vecs[i].ofs, vecs[i].exp);
        end
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_tcon", {30'd0, tcon_out}, 32'd0);

        // first expiry with auto-reload
        wr(0, 32'hFFFF_FFF0);
        wr(8, 32'd3);
        check("th_out", th_out, 32'hFFFF_FFF0);
        ts = 0;
        repeat (17) tick();
        ts = 1;
        tick();
        check("exp_irq", {31'd0, irq}, 32'd1);
        check("exp_reload_low", {30'd0, tcon_out}, 32'd2);
        rd_chk("exp_tcon", 8, 32'd7);
        tick();
        check("exp_reload_back", {30'd0, tcon_out}, 32'd3);

        // ack / eret / W1C
        pulse_ack();
        check("ack_irq", {31'd0, irq}, 32'd0);
        pulse_eret();
        check("eret_irq", {31'd0, irq}, 32'd0);
        rd_chk("eret_status", 8, 32'd7);
        wr(8, 32'd7);
        rd_chk("w1c_tcon", 8, 32'd3);

        // overruns in service and replay
        expire();
        pulse_ack();
        expire();
        expire();
        rd_chk("ovr_two", 12, 32'd2);
        check("svc_irq", {31'd0, irq}, 32'd0);
        pulse_eret();
        check("replay_irq", {31'd0, irq}, 32'd1);
        wr(12, 32'd0);
        rd_chk("ovr_clr", 12, 32'd0);

        // W1C racing an expiry while pending, then alone
        ts = 0; tick();
        ts = 1; bus.addr = BASE + 8; bus.wdata = 32'd7; bus.wr_en = 1;
        tick();
        bus.wr_en = 0;
        rd_chk("race_status", 8, 32'd7);
        check("race_irq", {31'd0, irq}, 32'd1);
        wr(8, 32'd7);
        check("cancel_irq", {31'd0, irq}, 32'd0);
        rd_chk("cancel_tcon", 8, 32'd3);

        // ack and eret together in pending: ack wins
        expire();
        ack = 1; eret = 1; tick(); ack = 0; eret = 0;
        check("ack_eret_irq", {31'd0, irq}, 32'd0);
        pulse_eret();
        check("ack_eret_idle", {31'd0, irq}, 32'd0);

        // reset in service with OVR=5
        wr(8, 32'd7);
        expire();
        pulse_ack();
        repeat (5) expire();
        rd_chk("ovr_five", 12, 32'd5);
        reset = 1; tick(); reset = 0;
        check("rst_irq", {31'd0, irq}, 32'd0);
        tl = 32'd0;
        for (int i = 0; i < 4; i++) rd_chk($sformatf("rst_rd[%0d]", i), 32'(i * 4), 32'd0);
        pulse_eret();
        check("rst_eret_irq", {31'd0, irq}, 32'd0);
        rd_chk("rst_eret_tcon", 8, 32'd0);

        // OVR saturation and clear racing an increment
        wr(8, 32'd3);
        expire();
        pulse_ack();
        repeat (260) expire();
        rd_chk("ovr_sat", 12, 32'd255);
        ts = 0; tick();
        ts = 1; bus.addr = BASE + 12; bus.wr_en = 1; tick(); bus.wr_en = 0;
        rd_chk("ovr_clr_inc", 12, 32'd1);
        pulse_eret();
        check("sat_replay_irq", {31'd0, irq}, 32'd1);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] exp_rd;
            reset     = ($urandom_range(0, 199) == 0);
            bus.addr  = BASE + 32'($urandom_range(0, 5) * 4);
            bus.rd_en = $urandom_range(0, 3) != 0;
            bus.wr_en = $urandom_range(0, 4) == 0;
            bus.wdata = $urandom();
            if (bus.addr == BASE + 8 && $urandom_range(0, 1) == 1) bus.wdata[1:0] = 2'b11;
            if ($urandom_range(0, 4) == 0) ts = ~ts;
            ack  = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            eret = $urandom_range(0, 5) == 0;
            tl   = $urandom();
            #1;
            exp_rd = model_rd(bus.addr, bus.rd_en, tl);
            check($sformatf("rnd_rdata[%0d]", c), bus.rdata, exp_rd);
            tick();
            check($sformatf("rnd_irq[%0d]", c), {31'd0, irq}, {31'd0, m_pend});
            check($sformatf("rnd_tcon[%0d]", c), {30'd0, tcon_out}, {30'd0, m_ie, m_en & ~m_reload});
            check($sformatf("rnd_th[%0d]", c), th_out, m_th);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
